// File: rtl/if_stage_fq.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_fq
// Brief    : Fetch stage with a DEPTH-entry fetch queue feeding decode.
//            Optional macro IF_ADEF_EN: misaligned fetch PCs raise fs_adef.
// Revision : 1.0  initial release
// ============================================================================
module if_stage_fq #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic             inst_sram_en,
  output logic [3:0]       inst_sram_we,
  output logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata,
  input  logic             ds_allowin,
  output logic             fs_to_ds_valid,
  output logic [63:0]      fs_to_ds_bus,
  output logic             fs_adef,
  output logic [CNT_W-1:0] fs_q_count
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_last_bus;
  logic [31:0]      r_q_inst [DEPTH];
  logic [31:0]      r_q_pc   [DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push_resp;
  logic             w_adef_push;
  logic             w_push;
  logic             w_misalign;
  logic             w_halted;
  logic             w_issue;
  logic [CNT_W:0]   w_credit;
  logic [CNT_W:0]   w_after_pop;
  logic [63:0]      w_head_bus;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & ds_allowin & ~br_taken;
  assign w_push_resp = r_inflight & ~br_taken;
  assign w_after_pop = {1'b0, r_count} - {{CNT_W{1'b0}}, w_pop};
  // Credit includes the outstanding request so its response always has a slot.
  assign w_credit    = w_after_pop + {{CNT_W{1'b0}}, r_inflight};

`ifdef IF_ADEF_EN
  logic r_halted;
  logic r_q_adef [DEPTH];

  assign w_misalign  = (r_fetch_pc[1:0] != 2'b00);
  assign w_halted    = r_halted;
  // Waits for the in-flight response so queue order stays in PC order.
  assign w_adef_push = w_misalign & ~r_halted & ~br_taken & ~r_inflight &
                       (w_after_pop < c_depth);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_halted <= 1'b0;
    end else if (br_taken) begin
      r_halted <= 1'b0;
    end else if (w_adef_push) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_adef[r_tail] <= w_adef_push;
    end
  end

  assign fs_adef = w_valid & r_q_adef[r_head];
`else
  assign w_misalign  = 1'b0;
  assign w_halted    = 1'b0;
  assign w_adef_push = 1'b0;
  assign fs_adef     = 1'b0;
`endif

  assign w_push  = w_push_resp | w_adef_push;
  assign w_issue = resetn & ~br_taken & ~w_halted & ~w_misalign & (w_credit < c_depth);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_tail] <= w_adef_push ? 32'h0 : inst_sram_rdata;
      r_q_pc[r_tail]   <= w_adef_push ? r_fetch_pc : r_req_pc;
    end
  end

  assign w_head_bus = {r_q_inst[r_head], r_q_pc[r_head]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_last_bus <= '0;
    end else if (br_taken) begin
      r_fetch_pc <= br_target;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head     <= r_head + PTR_W'(1);
        r_last_bus <= w_head_bus;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign inst_sram_en    = w_issue;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wdata = 32'h0;
  assign fs_to_ds_valid  = w_valid;
  assign fs_to_ds_bus    = w_valid ? w_head_bus : r_last_bus;
  assign fs_q_count      = r_count;

endmodule
`default_nettype wire

// File: doc/if_stage_fq.md
Name: if_stage_fq

Overview:
- Parametrised fetch stage that replaces the single-register pre-IF/IF pair in the CPU top.
- Holds the fetch PC and issues requests to the instruction SRAM, which has 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode through a valid/allowin handshake.
- A branch redirect from EX flushes the FIFO and the in-flight request.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- DEPTH, 4, fetch queue entries; power of 2, >=2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy output.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- br_taken  input  1  redirect pulse from EX, one cycle.
- br_target  input  32  redirect PC, valid when br_taken=1.
- inst_sram_en  output  1  request strobe.
- inst_sram_we  output  4  constant 0.
- inst_sram_addr  output  32  request PC.
- inst_sram_wdata  output  32  constant 0.
- inst_sram_rdata  input  32  read data, valid the cycle after the en cycle.
- ds_allowin  input  1  decode accepts this cycle.
- fs_to_ds_valid  output  1  queue head valid.
- fs_to_ds_bus  output  64  {inst[31:0], pc[31:0]} of the queue head.
- fs_adef  output  1  queue head carries a misaligned-fetch exception (see Optional Feature).
- fs_q_count  output  CNT_W  queue occupancy.

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty, inflight=0, halted=0.
  - Outputs: inst_sram_en=0, fs_to_ds_valid=0, fs_to_ds_bus=0, fs_adef=0, fs_q_count=0.
  - The first request is issued in the first cycle after resetn deasserts.
- pop = fs_to_ds_valid & ds_allowin & ~br_taken.
- push = inflight & ~br_taken. The response is written at the tail with the PC latched at request time.
- Issue rule: inst_sram_en = ~br_taken & ~halted & (count + inflight - pop < DEPTH).
  - inst_sram_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+4, inflight <= 1, req_pc <= fetch_pc. Otherwise inflight <= 0.
- Latency: an en in cycle N returns data in N+1, is pushed at the end of N+1, and is visible at decode (fs_to_ds_valid=1) in N+2.
- Throughput: one instruction per cycle once steady, for any DEPTH>=2 with decode always accepting.
- Full: the credit check counts the in-flight request, so a push never overflows. Push and pop in the same cycle leave count unchanged.
- Empty: fs_to_ds_valid=0 and fs_to_ds_bus holds its last value. The bus is don't-care when invalid.
- Redirect (br_taken=1 in cycle R):
  - Queue cleared (head=tail, count=0) and any response arriving in R is discarded.
  - No request is issued in R; fetch_pc <= br_target; halted <= 0.
  - The request at br_target is issued in R+1 and the instruction reaches decode in R+3.
  - br_taken takes priority over ds_allowin, push and issue.
- Back-to-back br_taken in R and R+1: the second target wins and the first target is never requested.
- Pointers wrap modulo DEPTH. fs_q_count = count, never exceeding DEPTH.
- resetn asserted mid-operation immediately clears all state (asynchronous). Any SRAM response outstanding is ignored after reset.

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined, when fetch_pc[1:0]!=0 and no redirect is in progress:
  - No SRAM request is issued.
  - One entry is pushed (once queue space exists) with inst=0, pc=fetch_pc and adef=1.
  - halted is then set, blocking further issue until the next br_taken.
  - fs_adef reflects the head entry's adef bit.
- Undefined:
  - Low PC bits are ignored; the request goes to the SRAM unchanged.
  - halted is never set and fs_adef is tied 0.
  - No adef storage is built.

Test Plan:
- Release reset with ds_allowin=1 and SRAM returning addr as data. inst_sram_en rises in cycle 1 with addr 1c000000. fs_to_ds_valid rises in cycle 3 with bus {1c000000,1c000000}, then PCs increment by 4 every cycle.
- Hold ds_allowin=0 with DEPTH=4. Exactly 4 requests are issued (1c000000..1c00000c), en stays 0 afterwards and fs_q_count=4. Releasing ds_allowin drains the entries in order with no duplicate or lost PC.
- With the queue full, toggle ds_allowin 1,0,1. One new request is issued per pop cycle, fs_q_count stays <=4 and the head order is preserved.
- Pulse br_taken with br_target=1c000100 while a request is in flight and 3 entries are queued:
  - Cycle R: queue empties, en=0, the in-flight data is dropped.
  - Cycle R+1: en with addr 1c000100.
  - Cycle R+3: valid with pc 1c000100.
  - Pulsing br_taken in both R and R+1 (targets 1c000100 then 1c000200) yields first fetch 1c000200.
- With IF_ADEF_EN defined, redirect to 1c000102. No SRAM request is issued to 1c000102 and one entry appears with fs_adef=1 and pc 1c000102. en then stays 0 until a redirect to 1c000200, after which fetch resumes there with fs_adef=0.
- Assert resetn=0 asynchronously mid-stream with the queue half full. fs_to_ds_valid and inst_sram_en drop immediately, and after release fetch restarts at 1c000000.
